// File: rtl/req_priority_encoder_if.sv
// Request/offer bundle for req_priority_encoder: request pulses in, one encoded
// index out per valid/ready handshake.
interface req_priority_encoder_if #(
   parameter int N = 4,
   parameter int W = 2
);
   logic [N-1:0] req_i;
   logic         ready_i;
   logic         valid_o;
   logic [W-1:0] idx_o;
   logic [N-1:0] onehot_o;
   logic [N-1:0] pending_o;
   logic         busy_o;

   // Event sources and the consumer drive through master.
   modport master (
      output req_i, ready_i,
      input  valid_o, idx_o, onehot_o, pending_o, busy_o
   );

   modport slave (
      input  req_i, ready_i,
      output valid_o, idx_o, onehot_o, pending_o, busy_o
   );
endinterface

// File: rtl/req_priority_encoder.sv
// Serialises multi-hot request pulses into a stream of binary indices, lowest
// index first, offered one per valid/ready handshake.
module req_priority_encoder #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   req_priority_encoder_if.slave bus
);

   typedef enum logic {IDLE, OFFER} state_t;

   state_t       state_p1, state_nxt;
   logic [W-1:0] idx_p1, idx_nxt;
   logic [N-1:0] onehot_p1, onehot_nxt;
   logic [N-1:0] pending_p1, pending_nxt;

   logic [N-1:0] cand;
   logic [N-1:0] sel;
   logic [W-1:0] sel_idx;
   logic         load;

   function automatic logic [N-1:0] lowest_onehot(input logic [N-1:0] v);
      return v & (~v + N'(1));
   endfunction

   function automatic logic [W-1:0] lowest_index(input logic [N-1:0] v);
      logic [W-1:0] r;
      r = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (v[k]) r = W'(k);
      end
      return r;
   endfunction

   assign cand    = pending_p1 | bus.req_i;
   assign sel     = lowest_onehot(cand);
   assign sel_idx = lowest_index(cand);

   always_comb begin
      state_nxt   = state_p1;
      idx_nxt     = idx_p1;
      onehot_nxt  = onehot_p1;
      load        = 1'b0;
      case (state_p1)
         IDLE: begin
            if (cand != '0) begin
               load      = 1'b1;
               state_nxt = OFFER;
            end
         end
         OFFER: begin
            if (bus.ready_i) begin
               if (cand != '0) begin
                  load = 1'b1;
               end else begin
                  // idx is deliberately held; only the one-hot echo is cleared.
                  onehot_nxt = '0;
                  state_nxt  = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (load) begin
         idx_nxt    = sel_idx;
         onehot_nxt = sel;
      end
      pending_nxt = cand & ~(load ? sel : '0);
   end

   // ---- stage p1: offer register and pending set ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_p1   <= IDLE;
         idx_p1     <= '0;
         onehot_p1  <= '0;
         pending_p1 <= '0;
      end else begin
         state_p1   <= state_nxt;
         idx_p1     <= idx_nxt;
         onehot_p1  <= onehot_nxt;
         pending_p1 <= pending_nxt;
      end
   end

   assign bus.valid_o   = (state_p1 == OFFER);
   assign bus.idx_o     = idx_p1;
   assign bus.onehot_o  = onehot_p1;
   assign bus.pending_o = pending_p1;
   assign bus.busy_o    = bus.valid_o | (|pending_p1);

endmodule

// File: doc/req_priority_encoder.md
Name: req_priority_encoder

Overview:
- Inverse of the one-hot decoders: collects up to N one-hot/multi-hot request pulses and returns them one at a time as a binary index.
- Requests are latched into a pending register. The highest-priority request (lowest index) is encoded into a registered binary index plus its one-hot echo.
- Each result is offered on a valid/ready handshake; a bit leaves pending only when it is loaded into the output register.
- Used wherever several event sources must be serialised into a binary select, e.g. exception/interrupt cause, writeback port arbitration.

Parameters:
- N, 4, number of request lines (N >= 2).
- W, 2, index width; must equal ceil(log2(N)). N=4/W=2 and N=8/W=3 are the supported configurations.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_i  input  N  request pulses; bit k high in a cycle = one event on source k. Multi-hot allowed.
- ready_i  input  1  consumer accepts current output when valid_o & ready_i.
- valid_o  output  1  idx_o/onehot_o hold a valid encoded request.
- idx_o  output  W  binary index of offered request.
- onehot_o  output  N  one-hot of idx_o when valid_o=1; all-zero when valid_o=0.
- pending_o  output  N  requests latched but not yet loaded into the output register.
- busy_o  output  1  valid_o | (|pending_o).

Behaviour:
- Reset (async, rst_n=0): state=IDLE, valid_o=0, idx_o=0, onehot_o=0, pending_o=0, busy_o=0. Reset mid-offer discards all pending and offered requests. Release is synchronous to clk.
- Candidate vector: cand = pending_o | req_i. Selection is fixed priority, lowest set index wins. sel = one-hot of the lowest set bit of cand; sel_idx = its binary index.
- FSM with two states:
  - IDLE (valid_o=0): if cand != 0, load idx_o=sel_idx and onehot_o=sel, set valid_o=1, go OFFER. Otherwise stay.
  - OFFER (valid_o=1): idx_o and onehot_o must stay stable while ready_i=0. On valid_o & ready_i:
    - if cand != 0, load the next selection the same cycle and stay in OFFER (back-to-back throughput, one per cycle);
    - otherwise clear valid_o and onehot_o, hold idx_o at its last value, go IDLE.
- Pending update each clock: pending_next = (pending_o | req_i) & ~(load ? sel : 0).
  - A req_i bit arriving in the same cycle as its load is consumed by that load; it is not double-counted.
  - A req_i for the index currently in OFFER (not being reloaded) sets pending, so it is offered again after acceptance.
  - Repeated requests on an already-pending bit merge into a single event; there is no counting.
- Latency: req_i sampled at edge t with the block idle -> valid_o=1 after edge t (first cycle after the request), zero bubbles.
- Starvation: fixed priority is intentional. A continuously asserted req_i[0] starves higher indices. Consumers requiring fairness must not use this block.
- busy_o is combinational from registered state only, so it never depends on req_i.
- ready_i while valid_o=0 is ignored.
- No X propagation: onehot_o is always derived from a registered one-hot, never from decoding idx_o while invalid.

Test Plan:
- Reset: assert rst_n=0 mid-OFFER with pending=4'b1010 -> immediately valid_o=0, onehot_o=0, pending_o=0, busy_o=0. After release with req_i=0, all outputs stay 0.
- Single request: req_i=4'b0100 for 1 cycle, ready_i=1 -> next cycle valid_o=1, idx_o=2, onehot_o=4'b0100, pending_o=0. Cycle after that valid_o=0, state IDLE.
- Multi-hot serialisation: req_i=4'b1011 for 1 cycle, ready_i=1 -> idx_o sequence 0,1,3 on three consecutive cycles. pending_o goes 4'b1010 -> 4'b1000 -> 0. Then valid_o drops.
- Backpressure stability: req_i=4'b0110, ready_i=0 for 5 cycles -> idx_o=1 and onehot_o=4'b0010 held stable, pending_o=4'b0100. Raise ready_i -> idx_o=2 next cycle.
- Simultaneous events: while offering idx 3 with ready_i=0, pulse req_i=4'b1001 -> pending_o=4'b1001. On accept, idx_o=0 then idx_o=3 (re-request honoured).
- Same-cycle load/request collision: idle, req_i=4'b0001 on two consecutive cycles with ready_i=1 -> idx_o=0 offered twice back-to-back, pending_o remains 0 throughout. Repeat with ready_i=0 for both cycles -> only one pending event recorded (pending_o=4'b0001 once).
